// File: rtl/tmod_slave_nch.sv
// Multi-channel temperature-module command slave: op/opnd command FSM plus
// per-channel samples, high/low thresholds, sticky alarms and an irq level.
module tmod_slave_nch #(
    parameter int NCH    = 4,
    parameter int DWIDTH = 8,
    parameter int OP_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OP_W-1:0]       op,
    input  logic [DWIDTH-1:0]     opnd,
    output logic [1:0]            status,
    output logic                  valid,
    output logic                  ready,
    output logic [DWIDTH-1:0]     rdata,
    input  logic [NCH*DWIDTH-1:0] temp_in,
    input  logic [NCH-1:0]        temp_stb,
    output logic                  irq
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DWIDTH:0] NCH_LIM = (DWIDTH + 1)'(NCH);

    localparam logic [OP_W-1:0] OP_SEL_CH     = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SET_HI     = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SET_LO     = OP_W'(3);
    localparam logic [OP_W-1:0] OP_READ_TEMP  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_READ_ALARM = OP_W'(5);
    localparam logic [OP_W-1:0] OP_CLR_ALARM  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SET_EN     = OP_W'(7);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_RANGE = 2'b01;
    localparam logic [1:0] ST_OP    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DWIDTH-1:0]   opnd_q, opnd_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic                en_q, en_d;
    logic [DWIDTH-1:0]   sample_q [NCH];
    logic [DWIDTH-1:0]   sample_d [NCH];
    logic [DWIDTH-1:0]   hi_q [NCH];
    logic [DWIDTH-1:0]   hi_d [NCH];
    logic [DWIDTH-1:0]   lo_q [NCH];
    logic [DWIDTH-1:0]   lo_d [NCH];
    logic [NCH-1:0]      alarm_hi_q, alarm_hi_d;
    logic [NCH-1:0]      alarm_lo_q, alarm_lo_d;
    logic [NCH-1:0]      clr_s;
    logic [DWIDTH-1:0]   slice_s;
    logic [1:0]          status_q, status_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                irq_q, irq_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;

    // Command FSM, sampling/alarm update and next-state of all registered outputs
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        sel_d      = sel_q;
        en_d       = en_q;
        sample_d   = sample_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        alarm_hi_d = alarm_hi_q;
        alarm_lo_d = alarm_lo_q;
        clr_s      = '0;
        slice_s    = '0;
        status_d   = status_q;
        rdata_d    = rdata_q;
        valid_d    = 1'b0;
        ready_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op != '0) begin
                    op_d    = op;
                    opnd_d  = opnd;
                    state_d = S_EXEC;
                    ready_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d  = S_RESP;
                valid_d  = 1'b1;
                status_d = ST_OK;
                case (op_q)
                    OP_SEL_CH: begin
                        if ({1'b0, opnd_q} < NCH_LIM) begin
                            sel_d = opnd_q[CH_W-1:0];
                        end else begin
                            status_d = ST_RANGE;
                        end
                        rdata_d = DWIDTH'(sel_d);
                    end
                    OP_SET_HI: begin
                        hi_d[sel_q] = opnd_q;
                        rdata_d     = opnd_q;
                    end
                    OP_SET_LO: begin
                        lo_d[sel_q] = opnd_q;
                        rdata_d     = opnd_q;
                    end
                    OP_READ_TEMP:  rdata_d = sample_q[sel_q];
                    OP_READ_ALARM: rdata_d = DWIDTH'({alarm_lo_q[sel_q], alarm_hi_q[sel_q]});
                    OP_CLR_ALARM: begin
                        clr_s[sel_q] = 1'b1;
                        rdata_d      = '0;
                    end
                    OP_SET_EN: begin
                        en_d    = opnd_q[0];
                        rdata_d = DWIDTH'(opnd_q[0]);
                    end
                    default: begin
                        status_d = ST_OP;
                        rdata_d  = '0;
                    end
                endcase
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Compares use pre-edge enable/thresholds; a same-cycle set beats a clear.
        for (int i = 0; i < NCH; i++) begin
            slice_s       = temp_in[i*DWIDTH +: DWIDTH];
            alarm_hi_d[i] = alarm_hi_q[i] & ~clr_s[i];
            alarm_lo_d[i] = alarm_lo_q[i] & ~clr_s[i];
            if (temp_stb[i]) begin
                sample_d[i] = slice_s;
                if (en_q && (slice_s > hi_q[i])) begin
                    alarm_hi_d[i] = 1'b1;
                end else begin
                    alarm_hi_d[i] = alarm_hi_d[i];
                end
                if (en_q && (slice_s < lo_q[i])) begin
                    alarm_lo_d[i] = 1'b1;
                end else begin
                    alarm_lo_d[i] = alarm_lo_d[i];
                end
            end else begin
                sample_d[i] = sample_q[i];
            end
        end

        irq_d = en_d & (|(alarm_hi_d | alarm_lo_d));
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            opnd_q     <= '0;
            sel_q      <= '0;
            en_q       <= 1'b0;
            alarm_hi_q <= '0;
            alarm_lo_q <= '0;
            status_q   <= ST_OK;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                sample_q[i] <= '0;
                hi_q[i]     <= '1;
                lo_q[i]     <= '0;
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            alarm_hi_q <= alarm_hi_d;
            alarm_lo_q <= alarm_lo_d;
            status_q   <= status_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            sample_q   <= sample_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign status = status_q;
    assign valid  = valid_q;
    assign ready  = ready_q;
    assign rdata  = rdata_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_tmod_slave_nch.sv
// Scoreboard bench for tmod_slave_nch: directed scenarios then random commands
// and strobes, checked against a channel-array reference model.
module tb_tmod_slave_nch;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int OPW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [OPW-1:0]    op;
    logic [DW-1:0]     opnd;
    logic [1:0]        status;
    logic              valid;
    logic              ready;
    logic [DW-1:0]     rdata;
    logic [NCH*DW-1:0] temp_in;
    logic [NCH-1:0]    temp_stb;
    logic              irq;

    tmod_slave_nch #(.NCH(NCH), .DWIDTH(DW), .OP_W(OPW)) dut (
        .clk(clk), .reset(reset), .op(op), .opnd(opnd), .status(status),
        .valid(valid), .ready(ready), .rdata(rdata), .temp_in(temp_in),
        .temp_stb(temp_stb), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one entry per channel, plain arithmetic
    int m_sample[NCH];
    int m_hi[NCH];
    int m_lo[NCH];
    bit m_ah[NCH];
    bit m_al[NCH];
    bit m_en;
    int m_sel;

    typedef struct {
        int vcyc;
        int st;
        int rd;
    } exp_t;
    exp_t sbq[$];

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_sample[i] = 0; m_hi[i] = 255; m_lo[i] = 0; m_ah[i] = 0; m_al[i] = 0;
        end
        m_en  = 0;
        m_sel = 0;
    endtask

    function automatic bit any_alarm();
        bit a = 0;
        for (int i = 0; i < NCH; i++) a |= m_ah[i] | m_al[i];
        return a;
    endfunction

    // One clock of effects; cmd=1 means this is the execute cycle of command opc
    task automatic model_cycle(input bit cmd, input int opc, input int opd,
                               input logic [NCH-1:0] m, input logic [NCH*DW-1:0] t,
                               input int ec);
        int st = 0, rd = 0, nsel = m_sel, v;
        bit nen = m_en;
        int nhi[NCH] = m_hi;
        int nlo[NCH] = m_lo;
        if (cmd) begin
            case (opc)
                1: begin if (opd < NCH) nsel = opd; else st = 1; rd = nsel; end
                2: begin nhi[m_sel] = opd; rd = opd; end
                3: begin nlo[m_sel] = opd; rd = opd; end
                4: rd = m_sample[m_sel];
                5: rd = 2 * m_al[m_sel] + m_ah[m_sel];
                6: begin m_ah[m_sel] = 0; m_al[m_sel] = 0; rd = 0; end
                7: begin nen = opd[0]; rd = opd % 2; end
                default: begin st = 2; rd = 0; end
            endcase
        end
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                v = int'(t[i*DW +: DW]);
                if (m_en && v > m_hi[i]) m_ah[i] = 1;
                if (m_en && v < m_lo[i]) m_al[i] = 1;
                m_sample[i] = v;
            end
        end
        m_sel = nsel; m_en = nen; m_hi = nhi; m_lo = nlo;
        if (cmd) sbq.push_back('{ec + 1, st, rd});
    endtask

    // Monitor: every valid pulse must match the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_valid: got valid=1, expected no response (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("valid_cycle", cyc, e.vcyc);
                chk("status", status, e.st);
                chk("rdata", rdata, e.rd);
            end
        end
    end

    task automatic idle(input logic [NCH-1:0] m, input logic [NCH*DW-1:0] t);
        chk("ready_idle", ready, 1);
        op = '0; opnd = DW'($urandom); temp_stb = m; temp_in = t;
        @(posedge clk);
        model_cycle(0, 0, 0, m, t, 0);
        @(negedge clk);
        temp_stb = '0;
        chk("irq", irq, m_en && any_alarm());
    endtask

    task automatic do_cmd(input int o, input int d, input logic [NCH-1:0] m, input logic [NCH*DW-1:0] t);
        int ec;
        chk("ready_accept", ready, 1);
        op = OPW'(o); opnd = DW'(d); temp_stb = '0;
        @(posedge clk);
        @(negedge clk);
        chk("irq", irq, m_en && any_alarm());
        ec = cyc;
        chk("ready_exec", ready, 0);
        op = OPW'($urandom); opnd = DW'($urandom); temp_stb = m; temp_in = t;
        @(posedge clk);
        model_cycle(1, o, d, m, t, ec);
        @(negedge clk);
        chk("irq", irq, m_en && any_alarm());
        chk("ready_resp", ready, 0);
        op = OPW'($urandom); temp_stb = '0;
        @(posedge clk);
        @(negedge clk);
        op = '0;
        chk("irq", irq, m_en && any_alarm());
    endtask

    task automatic cmd(input int o, input int d);
        do_cmd(o, d, '0, '0);
    endtask

    function automatic logic [NCH*DW-1:0] one_ch(input int ch, input int v);
        logic [NCH*DW-1:0] t = '0;
        t[ch*DW +: DW] = DW'(v);
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, o, d;
        logic [NCH-1:0] m;
        logic [NCH*DW-1:0] t;
        reset = 1'b1; op = '0; opnd = '0; temp_stb = '0; temp_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_status", status, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        reset = 1'b0;

        cmd(4, 0);
        cmd(1, 2); cmd(2, 8'h50); cmd(7, 1);
        idle(4'b0100, one_ch(2, 8'h51));
        chk("irq_after_strobe", irq, 1);
        cmd(5, 0);
        idle(4'b0100, one_ch(2, 8'h50));
        cmd(5, 0);
        cmd(1, 5); cmd(15, 8'h33); cmd(5, 0); cmd(4, 0);
        do_cmd(6, 0, 4'b0100, one_ch(2, 8'h60));
        cmd(5, 0); cmd(6, 0); cmd(5, 0);
        chk("irq_cleared", irq, 0);
        cmd(7, 0); cmd(1, 1); cmd(3, 8'h10);
        idle(4'b0010, one_ch(1, 8'h05));
        cmd(5, 0); cmd(7, 1);
        idle(4'b0010, one_ch(1, 8'h05));
        cmd(5, 0);
        do_cmd(4, 0, 4'b0010, one_ch(1, 8'h77));
        cmd(4, 0);

        // Reset during the execute cycle of SET_HI aborts it without a response
        cmd(1, 3);
        chk("ready_accept", ready, 1);
        op = 4'd2; opnd = 8'h20;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; op = '0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        chk("ready_after_reset", ready, 1);
        chk("valid_after_reset", valid, 0);
        cmd(1, 3); cmd(7, 1);
        idle(4'b1111, {NCH{8'hFF}});
        cmd(5, 0);
        chk("irq_after_reset", irq, 0);

        for (int n = 0; n < 300; n++) begin
            m = NCH'($urandom);
            t = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                idle(m, t);
            end else begin
                k = $urandom_range(1, 9);
                o = (k >= 8) ? $urandom_range(8, 15) : k;
                d = (o == 1) ? $urandom_range(0, 5) : $urandom_range(0, 255);
                if ($urandom_range(0, 1) == 0) m = '0;
                do_cmd(o, d, m, t);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
